ula_mc: RTL
===========

// Module: ula_mc
// PURPOSE
//   Parametrised, handshaked successor to the combinational integer ALU.
//   - Executes RV32I register-register (opcode 0110011) and register-immediate (0010011) ALU ops, plus MUL (RV32M, low XLEN bits) as a multi-cycle op.
//   - Sits between decode/operand fetch and writeback.
//   - One operation in flight at a time; result held until the consumer takes it.
// PARAMETERS
//   XLEN    32  operand/result width; power of two, >= 8
//   MUL_EN  1   1: MUL implemented (iterative shift-add); 0: MUL flagged illegal
// PORTS
//   clk        in   1     clock, rising edge
//   rst_n      in   1     synchronous active-low reset
//   in_valid   in   1     operation request valid
//   in_ready   out  1     block can accept a request
//   opcode     in   7     instruction opcode
//   funct3     in   3     instruction funct3
//   funct7     in   7     instruction funct7 (I-type: upper imm bits, used for shifts only)
//   data1_in   in   XLEN  rs1 operand
//   data2_in   in   XLEN  rs2 operand or sign-extended immediate
//   out_valid  out  1     result valid
//   out_ready  in   1     consumer takes result
//   data_out   out  XLEN  result
//   illegal    out  1     op code not supported; qualified by out_valid
// BEHAVIOUR
//   Reset: synchronous active-low, single clock.
//   - While rst_n=0 at an edge: state<=IDLE, out_valid<=0, data_out<=0, illegal<=0, counter and multiplier registers <=0.
//   - Reset mid-MUL aborts the op; no result is produced.
//   FSM states: IDLE, MUL, DONE. in_ready = (state==IDLE), combinational; no overlap of ops.
//   - IDLE: on in_valid at an edge, operands and code are latched.
//     - Single-cycle op or illegal code: data_out/illegal registered, -> DONE.
//     - MUL with MUL_EN=1: -> MUL.
//   - MUL: one multiplier bit per cycle for XLEN cycles, using a log2(XLEN)-bit counter, then -> DONE.
//   - DONE: out_valid=1; data_out and illegal are stable. On out_ready at an edge -> IDLE, out_valid<=0.
//   Latency from accept edge to out_valid=1 (back-pressure holds DONE indefinitely):
//   - Single-cycle ops and illegal codes: 1 edge.
//   - MUL: XLEN+1 edges.
//   Shift amount is always data2_in[log2(XLEN)-1:0]; upper bits ignored.
//   Op table, R-type {funct3,funct7} / I-type:
//   - ADD 000,0000000 / ADDI 000, funct7 ignored
//   - SUB 000,0100000 / none
//   - SLL 001,0000000 / SLLI 001,0000000
//   - SLT 010,0000000 / SLTI 010: signed compare, result 1 or 0
//   - SLTU 011,0000000 / SLTIU 011: unsigned compare
//   - XOR 100 / XORI; OR 110 / ORI; AND 111 / ANDI
//     (R-type funct7=0000000; I-type funct7 ignored)
//   - SRL 101,0000000 / SRLI; SRA 101,0100000 / SRAI (arithmetic)
//   - MUL 000,0000001 (R only): low XLEN bits of data1_in*data2_in, signedness irrelevant
//   Any other {opcode,funct3,funct7} -> data_out=0, illegal=1, 1-edge latency.
//   - This includes MUL when MUL_EN=0 and the other RV32M funct3 values.
//   Arithmetic wraps modulo 2^XLEN; no overflow flag.
//   Inputs are sampled only at the accept edge; changes afterwards have no effect.
// TESTING
//   1. ADD 5+7, out_ready=1 -> out_valid 1 edge after accept, data_out=0x0000000C, illegal=0.
//   2. SUB 3-5 -> 0xFFFFFFFE; SLT(0xFFFFFFFF,1) -> 1; SLTU(0xFFFFFFFF,1) -> 0.
//   3. SRA 0x80000000 by 4 -> 0xF8000000; SLL 1 by data2=33 -> 0x00000002.
//   4. MUL 0xFFFFFFFF*3 -> 0xFFFFFFFD at edge 33 after accept.
//      - in_ready=0 from edge 1 until the result is taken.
//   5. Back-pressure: out_ready=0 for 5 cycles -> out_valid and data_out held; next accept only after handshake.
//   6. opcode 0110011, funct7 1111111 -> illegal=1, data_out=0.
//      - rst_n=0 at edge 10 of a MUL -> out_valid never rises, in_ready=1 after reset.

Source files
------------

// File: rtl/ula_mc.sv
// ula_mc: handshaked integer ALU for RV32I OP/OP-IMM instructions plus an
// iterative shift-add MUL. Accepts one operation at a time in IDLE, holds the
// registered result in DONE until the consumer takes it.
module ula_mc #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] data1_in,
  input  logic [XLEN-1:0] data2_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] data_out,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [XLEN-1:0] mcand_r, mplier_r, acc_r, acc_nxt_s;
  logic [SHW-1:0]  cnt_r;
  logic [XLEN-1:0] data_out_r;
  logic            illegal_r, out_valid_r;

  logic [XLEN-1:0] alu_res_s;
  logic            alu_ill_s, is_mul_s;

  // Single-cycle ALU; alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic logic [XLEN-1:0] alu_calc(input logic [2:0] f3, input logic alt,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        r;
    sa = a;
    sh = b[SHW-1:0];
    r  = '0;
    case (f3)
      3'b000: begin
        if (alt) r = a - b;
        else     r = a + b;
      end
      3'b001: r = a << sh;
      3'b010: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011: r = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100: r = a ^ b;
      3'b101: begin
        if (alt) r = sa >>> sh;
        else     r = a >> sh;
      end
      3'b110: r = a | b;
      3'b111: r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign data_out  = data_out_r;
  assign illegal   = illegal_r;

  // Decode the presented instruction into a result, an illegal flag or a MUL request.
  always_comb begin
    alu_res_s = '0;
    alu_ill_s = 1'b1;
    is_mul_s  = 1'b0;
    if (opcode == OPC_OP) begin
      if (funct7 == F7_BASE) begin
        alu_ill_s = 1'b0;
        alu_res_s = alu_calc(funct3, 1'b0, data1_in, data2_in);
      end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
        alu_ill_s = 1'b0;
        alu_res_s = alu_calc(funct3, 1'b1, data1_in, data2_in);
      end else if (funct7 == F7_MULDIV && funct3 == 3'b000 && MUL_EN) begin
        alu_ill_s = 1'b0;
        is_mul_s  = 1'b1;
      end else begin
        alu_ill_s = 1'b1;
      end
    end else if (opcode == OPC_IMM) begin
      case (funct3)
        3'b001: begin
          if (funct7 == F7_BASE) begin
            alu_ill_s = 1'b0;
            alu_res_s = alu_calc(funct3, 1'b0, data1_in, data2_in);
          end else begin
            alu_ill_s = 1'b1;
          end
        end
        3'b101: begin
          if (funct7 == F7_BASE || funct7 == F7_ALT) begin
            alu_ill_s = 1'b0;
            alu_res_s = alu_calc(funct3, (funct7 == F7_ALT), data1_in, data2_in);
          end else begin
            alu_ill_s = 1'b1;
          end
        end
        default: begin
          // Remaining I-type ops ignore funct7 (it is immediate data).
          alu_ill_s = 1'b0;
          alu_res_s = alu_calc(funct3, 1'b0, data1_in, data2_in);
        end
      endcase
    end else begin
      alu_ill_s = 1'b1;
    end
  end

  // One shift-add step: accumulate the multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_nxt_s = acc_r;
    if (mplier_r[0]) acc_nxt_s = acc_r + mcand_r;
    else             acc_nxt_s = acc_r;
  end

  // Next-state logic for the IDLE -> (MUL) -> DONE -> IDLE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = is_mul_s ? MUL : DONE;
        else          state_nxt_s = IDLE;
      end
      MUL: begin
        if (cnt_r == CNT_LAST) state_nxt_s = DONE;
        else                   state_nxt_s = MUL;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Operand latching, multiplier iteration and registered result/handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r     <= '0;
      mplier_r    <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      data_out_r  <= '0;
      illegal_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            if (is_mul_s) begin
              mcand_r  <= data1_in;
              mplier_r <= data2_in;
              acc_r    <= '0;
              cnt_r    <= '0;
            end else begin
              data_out_r  <= alu_res_s;
              illegal_r   <= alu_ill_s;
              out_valid_r <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_r    <= acc_nxt_s;
          mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
          cnt_r    <= cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            data_out_r  <= acc_nxt_s;
            illegal_r   <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule
